// File: rtl/tx_arbiter_scheduler.sv
// tx_arbiter_scheduler: three-source round-robin arbiter feeding a start/data/stop serializer.
// Define TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module tx_arbiter_scheduler #(
  parameter int width_byte   = 8,
  parameter int clks_per_bit = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              i_req,
  input  logic [2*width_byte-1:0] i_a,
  input  logic [2*width_byte-1:0] i_b,
  input  logic [2*width_byte-1:0] i_c,
  output logic [2:0]              o_gnt,
  output logic [1:0]              o_src,
  output logic                    o_tx,
  output logic                    o_busy
);

  localparam int DW  = 2 * width_byte;
  localparam int BCW = (DW > 1) ? $clog2(DW) : 1;
  localparam int DCW = (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;

`ifdef TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t          state_q, state_d;
  logic [DCW-1:0]  div_q;
  logic [BCW-1:0]  bit_q;
  logic [DW-1:0]   shift_q;
  logic [1:0]      last_q;
  logic [1:0]      src_q;
  logic            armed_q;
`ifdef TX_PARITY_EN
  logic            par_q;
`endif

  logic            win_vld;
  logic [1:0]      win_idx;
  logic [1:0]      cand;
  logic [DW-1:0]   win_word;
  logic            grant;
  logic            div_last;
  logic            bit_last;

  // Search starts one past the last granted source and wraps a->b->c->a.
  always_comb begin
    win_vld = 1'b0;
    win_idx = 2'd0;
    cand    = 2'd0;
    for (int k = 1; k <= 3; k++) begin
      cand = 2'((32'(last_q) + k) % 3);
      if (!win_vld && i_req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    case (win_idx)
      2'd1:    win_word = i_b;
      2'd2:    win_word = i_c;
      default: win_word = i_a;
    endcase
  end

  // armed_q blocks a grant on the edge that coincides with reset release.
  assign grant    = armed_q && (state_q == IDLE) && win_vld;
  assign o_gnt    = grant ? (3'b001 << win_idx) : 3'b000;
  assign div_last = (div_q == DCW'(clks_per_bit - 1));
  assign bit_last = (bit_q == BCW'(DW - 1));
  assign o_busy   = (state_q != IDLE);
  assign o_src    = src_q;

  always_comb begin
    state_d = state_q;
    o_tx    = 1'b1;
    case (state_q)
      IDLE: begin
        if (grant) state_d = START;
      end
      START: begin
        o_tx = 1'b0;
        if (div_last) state_d = DATA;
      end
      DATA: begin
        o_tx = shift_q[0];
`ifdef TX_PARITY_EN
        if (div_last && bit_last) state_d = PAR;
`else
        if (div_last && bit_last) state_d = STOP;
`endif
      end
`ifdef TX_PARITY_EN
      PAR: begin
        o_tx = par_q;
        if (div_last) state_d = STOP;
      end
`endif
      STOP: begin
        if (div_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      last_q  <= 2'd2;
      src_q   <= 2'd0;
      armed_q <= 1'b0;
`ifdef TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      armed_q <= 1'b1;
      state_q <= state_d;
      if (grant) begin
        shift_q <= win_word;
        src_q   <= win_idx;
        last_q  <= win_idx;
        div_q   <= '0;
        bit_q   <= '0;
`ifdef TX_PARITY_EN
        par_q   <= ^win_word;
`endif
      end else if (state_q != IDLE) begin
        if (div_last) begin
          div_q <= '0;
          if (state_q == DATA) begin
            shift_q <= shift_q >> 1;
            bit_q   <= bit_last ? '0 : bit_q + BCW'(1);
          end
        end else begin
          div_q <= div_q + DCW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_tx_arbiter_scheduler.sv
// Randomized self-checking bench for tx_arbiter_scheduler: a default instance and a one-clock-per-bit instance.
// Expected serial frames are built from the captured word as a list of line levels.
module tb_tx_arbiter_scheduler;

  localparam int W            = 8;
  localparam int DW           = 2 * W;
  localparam int CPB          = 4;
  localparam int GRANT_BUDGET = 50;

  logic          clk;
  logic          rst;
  logic [2:0]    req;
  logic [DW-1:0] a_word, b_word, c_word;
  logic [2:0]    gnt;
  logic [1:0]    src;
  logic          tx;
  logic          busy;

  logic [2:0]    f_req;
  logic [DW-1:0] f_a, f_b, f_c;
  logic [2:0]    f_gnt;
  logic [1:0]    f_src;
  logic          f_tx;
  logic          f_busy;

  int vectors     = 0;
  int miscompares = 0;
  int model_last  = 2;

  tx_arbiter_scheduler #(.width_byte(W), .clks_per_bit(CPB)) dut (
    .clk(clk), .rst(rst), .i_req(req), .i_a(a_word), .i_b(b_word), .i_c(c_word),
    .o_gnt(gnt), .o_src(src), .o_tx(tx), .o_busy(busy)
  );

  tx_arbiter_scheduler #(.width_byte(W), .clks_per_bit(1)) dut_fast (
    .clk(clk), .rst(rst), .i_req(f_req), .i_a(f_a), .i_b(f_b), .i_c(f_c),
    .o_gnt(f_gnt), .o_src(f_src), .o_tx(f_tx), .o_busy(f_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Round-robin reference: first requester after the previous winner, wrapping a->b->c.
  function automatic int rr_pick(input logic [2:0] r, input int last);
    for (int k = 1; k <= 3; k++) begin
      if (r[(last + k) % 3]) return (last + k) % 3;
    end
    return -1;
  endfunction

  function automatic void build_frame(input logic [DW-1:0] word, output logic bits[$]);
    bits = {};
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(word[i]);
`ifdef TX_PARITY_EN
    bits.push_back(^word);
`endif
    bits.push_back(1'b1);
  endfunction

  // Entered at (or shortly after) a falling edge; checks the grant, then every frame cycle, then the idle cycle.
  task automatic serve_frame(input int exp_src, input bit immediate, input bit scramble,
                             input logic [2:0] req_after);
    logic [DW-1:0] word;
    logic          bits[$];
    int            len;
    bit            seen;
    #1;
    seen = (gnt !== 3'b000);
    if (!immediate) begin
      for (int i = 0; i < GRANT_BUDGET && !seen; i++) begin
        @(negedge clk); #1;
        seen = (gnt !== 3'b000);
      end
    end
    vectors++;
    if (gnt !== 3'(1 << exp_src) || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL grant: got gnt=%b busy=%b, want gnt=%b busy=0", gnt, busy, 3'(1 << exp_src));
      req = 3'b000;
      return;
    end
    word = (exp_src == 0) ? a_word : (exp_src == 1) ? b_word : c_word;
    model_last = exp_src;
    build_frame(word, bits);
    len = bits.size() * CPB;
    @(negedge clk);
    req = req_after;
    if (scramble) begin
      a_word = DW'($urandom);
      b_word = DW'($urandom);
      c_word = DW'($urandom);
    end
    vectors++;
    if (src !== 2'(exp_src)) begin
      miscompares++;
      $display("FAIL src: got %0d, want %0d", src, exp_src);
    end
    for (int cyc = 0; cyc < len; cyc++) begin
      if (cyc > 0) @(negedge clk);
      vectors++;
      if ({gnt, busy, tx} !== {3'b000, 1'b1, bits[cyc / CPB]}) begin
        miscompares++;
        $display("FAIL frame cycle %0d: got gnt=%b busy=%b tx=%b, want gnt=000 busy=1 tx=%b",
                 cyc, gnt, busy, tx, bits[cyc / CPB]);
      end
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      miscompares++;
      $display("FAIL frame end: got busy=%b tx=%b, want busy=0 tx=1", busy, tx);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    req = 3'b000; a_word = '0; b_word = '0; c_word = '0;
    f_req = 3'b000; f_a = '0; f_b = '0; f_c = '0;
    #12;
    vectors++;
    if ({gnt, src, tx, busy} !== {3'b000, 2'd0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL reset: got gnt=%b src=%0d tx=%b busy=%b, want 000/0/1/0", gnt, src, tx, busy);
    end
    vectors++;
    if ({f_gnt, f_src, f_tx, f_busy} !== {3'b000, 2'd0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL reset fast: got gnt=%b src=%0d tx=%b busy=%b, want 000/0/1/0",
               f_gnt, f_src, f_tx, f_busy);
    end
    @(negedge clk); #2;
    rst = 1'b1;
    model_last = 2;
    @(negedge clk);
  endtask

  task automatic test_round_robin;
    int order[4] = '{0, 1, 2, 0};
    a_word = DW'($urandom); b_word = DW'($urandom); c_word = DW'($urandom);
    req = 3'b111;
    for (int i = 0; i < 4; i++) begin
      serve_frame(order[i], i > 0, 1'b1, (i == 3) ? 3'b000 : 3'b111);
    end
  endtask

  task automatic test_fixed_frame;
    a_word = 16'hA55A;
    req = 3'b001;
    serve_frame(0, 1'b0, 1'b0, 3'b000);
  endtask

  task automatic test_mid_frame_change;
    b_word = DW'($urandom);
    req = 3'b010;
    serve_frame(1, 1'b0, 1'b1, 3'b001);
    serve_frame(0, 1'b1, 1'b0, 3'b000);
  endtask

  task automatic test_parity_words;
    a_word = 16'h0001;
    req = 3'b001;
    serve_frame(0, 1'b0, 1'b0, 3'b000);
    a_word = 16'h0003;
    req = 3'b001;
    serve_frame(0, 1'b0, 1'b0, 3'b000);
  endtask

  task automatic test_random;
    logic [2:0] r;
    for (int n = 0; n < 8; n++) begin
      r = 3'($urandom_range(1, 7));
      a_word = DW'($urandom); b_word = DW'($urandom); c_word = DW'($urandom);
      req = r;
      serve_frame(rr_pick(r, model_last), 1'b0, 1'b1, 3'b000);
    end
  endtask

  task automatic test_reset_mid_frame;
    bit seen;
    a_word = DW'($urandom);
    req = 3'b001;
    #1;
    seen = (gnt !== 3'b000);
    for (int i = 0; i < GRANT_BUDGET && !seen; i++) begin
      @(negedge clk); #1;
      seen = (gnt !== 3'b000);
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL reset-frame grant: got gnt=%b, want nonzero", gnt);
    end
    @(negedge clk);
    req = 3'b000;
    repeat (29) @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL pre-abort busy: got %b, want 1", busy);
    end
    #2;
    rst = 1'b0;
    #1;
    vectors++;
    if ({tx, busy, gnt} !== {1'b1, 1'b0, 3'b000}) begin
      miscompares++;
      $display("FAIL abort: got tx=%b busy=%b gnt=%b, want tx=1 busy=0 gnt=000", tx, busy, gnt);
    end
    @(negedge clk);
    req = 3'b100;
    c_word = DW'($urandom);
    @(negedge clk); #2;
    rst = 1'b1;
    model_last = 2;
    #1;
    vectors++;
    if (gnt !== 3'b000) begin
      miscompares++;
      $display("FAIL release grant: got %b, want 000", gnt);
    end
    serve_frame(2, 1'b0, 1'b1, 3'b000);
  endtask

  task automatic fast_frame(input int exp_src, input logic [DW-1:0] word);
    logic bits[$];
    bit   seen;
    #1;
    seen = (f_gnt !== 3'b000);
    for (int i = 0; i < GRANT_BUDGET && !seen; i++) begin
      @(negedge clk); #1;
      seen = (f_gnt !== 3'b000);
    end
    vectors++;
    if (f_gnt !== 3'(1 << exp_src)) begin
      miscompares++;
      $display("FAIL fast grant: got %b, want %b", f_gnt, 3'(1 << exp_src));
      f_req = 3'b000;
      return;
    end
    build_frame(word, bits);
    @(negedge clk);
    f_req = 3'b000;
    f_a = DW'($urandom); f_b = DW'($urandom); f_c = DW'($urandom);
    vectors++;
    if (f_src !== 2'(exp_src)) begin
      miscompares++;
      $display("FAIL fast src: got %0d, want %0d", f_src, exp_src);
    end
    for (int cyc = 0; cyc < bits.size(); cyc++) begin
      if (cyc > 0) @(negedge clk);
      vectors++;
      if ({f_gnt, f_busy, f_tx} !== {3'b000, 1'b1, bits[cyc]}) begin
        miscompares++;
        $display("FAIL fast bit %0d: got gnt=%b busy=%b tx=%b, want gnt=000 busy=1 tx=%b",
                 cyc, f_gnt, f_busy, f_tx, bits[cyc]);
      end
    end
    @(negedge clk);
    vectors++;
    if (f_busy !== 1'b0 || f_tx !== 1'b1) begin
      miscompares++;
      $display("FAIL fast end: got busy=%b tx=%b, want busy=0 tx=1", f_busy, f_tx);
    end
  endtask

  task automatic test_clks_per_bit_one;
    logic [DW-1:0] w;
    f_c = 16'hFFFF;
    f_req = 3'b100;
    fast_frame(2, 16'hFFFF);
    w = DW'($urandom);
    f_a = w;
    f_req = 3'b001;
    fast_frame(0, w);
  endtask

  initial begin
    test_reset;
    test_round_robin;
    test_fixed_frame;
    test_mid_frame_change;
    test_parity_words;
    test_random;
    test_reset_mid_frame;
    test_clks_per_bit_one;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
